// File: rtl/spi_page_write_ctrl.sv
// Page-program sequencer for an SPI flash/SRAM behind spi_memory_master.
// Runs WREN, then PAGE PROGRAM with address and a streamed burst of bytes,
// then RDSR polling until the write-in-progress bit clears or the poll
// budget runs out. All master trigger lines are owned here and at most one
// is high at a time; each follows the current state, so it falls the cycle
// after its acknowledge is seen.
module spi_page_write_ctrl #(
  parameter int         ADDR_BYTES = 1,
  parameter int         LEN_W      = 9,
  parameter int         POLL_LIMIT = 1024,
  parameter logic [7:0] OP_WREN    = 8'h06,
  parameter logic [7:0] OP_PP      = 8'h02,
  parameter logic [7:0] OP_RDSR    = 8'h05
) (
  input  logic                    main_clock_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [8*ADDR_BYTES-1:0] start_addr_i,
  input  logic [LEN_W-1:0]        length_i,
  input  logic [7:0]              byte_data_i,
  input  logic                    byte_valid_i,
  output logic                    byte_ready_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [7:0]              spi_opcode_o,
  output logic [8*ADDR_BYTES-1:0] spi_addr_o,
  output logic                    spi_addr_flag_o,
  output logic [3:0]              spi_dummy_cycles_o,
  output logic [7:0]              spi_write_data_o,
  input  logic [7:0]              spi_read_data_i,
  output logic                    spi_opcode_addr_trigger_o,
  input  logic                    spi_opcode_addr_completed_i,
  output logic                    spi_data_trigger_o,
  input  logic                    spi_data_ready_i,
  input  logic                    spi_data_completed_i,
  output logic                    spi_finalize_trigger_o,
  input  logic                    spi_busy_i
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int PW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

  typedef enum logic [3:0] {
    IDLE,
    WREN_CMD,
    WREN_FIN,
    PP_CMD,
    PP_WAIT,
    PP_DATA,
    PP_FIN,
    POLL_CMD,
    POLL_DATA,
    POLL_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [LEN_W-1:0]  length_q, length_d;
  // Bytes of the burst the master has not yet latched.
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  // Master took the current byte but the stream had nothing to offer yet.
  logic              needByte_q, needByte_d;
  logic [7:0]        writeData_q, writeData_d;
  logic              wip_q, wip_d;
  logic [PW-1:0]     pollCount_q, pollCount_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              byteReady;
  logic              oaTrig;
  logic              dataTrig;
  logic              finTrig;
  logic [7:0]        opcode;
  logic [AW-1:0]     addrOut;
  logic              addrFlag;
  logic [LEN_W-1:0]  remNext;
  logic              unusedStatusBits;

  // Only the WIP bit of the status register matters to this sequencer.
  assign unusedStatusBits = ^spi_read_data_i[7:1];

  // State register; reset returns to IDLE so every trigger drops at once.
  always_ff @(posedge main_clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched request, burst bookkeeping, poll status and end-of-job pulses.
  always_ff @(posedge main_clock_i or posedge reset_i) begin
    if (reset_i) begin
      addr_q      <= '0;
      length_q    <= '0;
      remaining_q <= '0;
      needByte_q  <= 1'b0;
      writeData_q <= '0;
      wip_q       <= 1'b0;
      pollCount_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      length_q    <= length_d;
      remaining_q <= remaining_d;
      needByte_q  <= needByte_d;
      writeData_q <= writeData_d;
      wip_q       <= wip_d;
      pollCount_q <= pollCount_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Next-state logic and the per-state command/trigger outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    length_d    = length_q;
    remaining_d = remaining_q;
    needByte_d  = needByte_q;
    writeData_d = writeData_q;
    wip_d       = wip_q;
    pollCount_d = pollCount_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    byteReady   = 1'b0;
    oaTrig      = 1'b0;
    dataTrig    = 1'b0;
    finTrig     = 1'b0;
    opcode      = OP_WREN;
    addrOut     = '0;
    addrFlag    = 1'b0;
    remNext     = remaining_q - LEN_W'(1);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (length_i != '0) begin
            addr_d      = start_addr_i;
            length_d    = length_i;
            pollCount_d = '0;
            needByte_d  = 1'b0;
            state_d     = WREN_CMD;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      WREN_CMD: begin
        oaTrig = 1'b1;
        if (spi_opcode_addr_completed_i) state_d = WREN_FIN;
      end

      WREN_FIN: begin
        finTrig = 1'b1;
        if (!spi_busy_i) state_d = PP_CMD;
      end

      PP_CMD: begin
        opcode   = OP_PP;
        addrOut  = addr_q;
        addrFlag = 1'b1;
        oaTrig   = 1'b1;
        if (spi_opcode_addr_completed_i) state_d = PP_WAIT;
      end

      PP_WAIT: begin
        opcode = OP_PP;
        if (byte_valid_i) begin
          byteReady   = 1'b1;
          writeData_d = byte_data_i;
          remaining_d = length_q;
          state_d     = PP_DATA;
        end
      end

      PP_DATA: begin
        opcode   = OP_PP;
        dataTrig = 1'b1;
        if (needByte_q) begin
          // Master is parked between bytes until a fresh byte arrives.
          if (byte_valid_i) begin
            byteReady   = 1'b1;
            writeData_d = byte_data_i;
            needByte_d  = 1'b0;
          end
        end else if (spi_data_ready_i) begin
          remaining_d = remNext;
          if (remNext != '0) begin
            if (byte_valid_i) begin
              byteReady   = 1'b1;
              writeData_d = byte_data_i;
            end else begin
              needByte_d = 1'b1;
            end
          end
        end
        if (spi_data_completed_i && (remaining_q == '0)) state_d = PP_FIN;
      end

      PP_FIN: begin
        opcode  = OP_PP;
        finTrig = 1'b1;
        if (!spi_busy_i) state_d = POLL_CMD;
      end

      POLL_CMD: begin
        opcode = OP_RDSR;
        oaTrig = 1'b1;
        if (spi_opcode_addr_completed_i) state_d = POLL_DATA;
      end

      POLL_DATA: begin
        opcode   = OP_RDSR;
        dataTrig = 1'b1;
        if (spi_data_completed_i) begin
          wip_d   = spi_read_data_i[0];
          state_d = POLL_FIN;
        end
      end

      POLL_FIN: begin
        opcode  = OP_RDSR;
        finTrig = 1'b1;
        if (!spi_busy_i) begin
          if (!wip_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (pollCount_q == POLL_LAST) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            pollCount_d = pollCount_q + PW'(1);
            state_d     = POLL_CMD;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign byte_ready_o              = byteReady;
  assign busy_o                    = (state_q != IDLE);
  assign done_o                    = done_q;
  assign error_o                   = error_q;
  assign spi_opcode_o              = opcode;
  assign spi_addr_o                = addrOut;
  assign spi_addr_flag_o           = addrFlag;
  assign spi_dummy_cycles_o        = 4'd0;
  assign spi_write_data_o          = writeData_q;
  assign spi_opcode_addr_trigger_o = oaTrig;
  assign spi_data_trigger_o        = dataTrig;
  assign spi_finalize_trigger_o    = finTrig;

endmodule

// File: tb/tb_spi_page_write_ctrl.sv
// Bench for spi_page_write_ctrl: a behavioural SPI master records every
// frame it shifts, the bench predicts the frame log of each transaction
// from the transaction itself, and a per-cycle monitor watches protocol
// rules on the controller outputs.
module tb_spi_page_write_ctrl;

  localparam int LEN_W      = 9;
  localparam int POLL_LIMIT = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [7:0]       startAddr;
  logic [LEN_W-1:0] length;
  logic [7:0]       byteData;
  logic             byteValid;
  logic             byteReady;
  logic             busy;
  logic             done;
  logic             error;
  logic [7:0]       spiOpcode;
  logic [7:0]       spiAddr;
  logic             spiAddrFlag;
  logic [3:0]       spiDummy;
  logic [7:0]       spiWdata;
  logic [7:0]       sRead;
  logic             oaTrig;
  logic             sOaComp;
  logic             dTrig;
  logic             sDReady;
  logic             sDComp;
  logic             finTrig;
  logic             sBusy;

  spi_page_write_ctrl #(
    .ADDR_BYTES(1),
    .LEN_W(LEN_W),
    .POLL_LIMIT(POLL_LIMIT)
  ) dut (
    .main_clock_i(clk),
    .reset_i(rst),
    .start_i(start),
    .start_addr_i(startAddr),
    .length_i(length),
    .byte_data_i(byteData),
    .byte_valid_i(byteValid),
    .byte_ready_o(byteReady),
    .busy_o(busy),
    .done_o(done),
    .error_o(error),
    .spi_opcode_o(spiOpcode),
    .spi_addr_o(spiAddr),
    .spi_addr_flag_o(spiAddrFlag),
    .spi_dummy_cycles_o(spiDummy),
    .spi_write_data_o(spiWdata),
    .spi_read_data_i(sRead),
    .spi_opcode_addr_trigger_o(oaTrig),
    .spi_opcode_addr_completed_i(sOaComp),
    .spi_data_trigger_o(dTrig),
    .spi_data_ready_i(sDReady),
    .spi_data_completed_i(sDComp),
    .spi_finalize_trigger_o(finTrig),
    .spi_busy_i(sBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // ---------------- behavioural SPI master ----------------
  // Log entry: bit 8 marks the first byte (opcode) of a CS frame.
  logic [8:0] mosiLog[$];
  logic [7:0] statusQ[$];
  int         rdsrFrames;
  int         pending;
  int         mCnt;
  bit         isPP;
  bit         mLatch;

  typedef enum {M_IDLE, M_OPADDR, M_GAP, M_OPEN, M_DATA, M_FIN} mstate_t;
  mstate_t mState;

  // Master shifts the opcode/address, data bytes on demand and releases CS
  // on finalize; in a PP frame it waits for a byte handed over by byte_ready.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mState  <= M_IDLE;
      sBusy   <= 1'b0;
      sOaComp <= 1'b0;
      sDReady <= 1'b0;
      sDComp  <= 1'b0;
      sRead   <= 8'h00;
      pending <= 0;
      mCnt    <= 0;
      isPP    <= 1'b0;
    end else begin
      sOaComp <= 1'b0;
      sDReady <= 1'b0;
      sDComp  <= 1'b0;
      mLatch  = 1'b0;
      case (mState)
        M_IDLE: if (oaTrig) begin
          sBusy <= 1'b1;
          mosiLog.push_back({1'b1, spiOpcode});
          if (spiAddrFlag) mosiLog.push_back({1'b0, spiAddr});
          isPP <= (spiOpcode == 8'h02);
          if (spiOpcode == 8'h05) rdsrFrames++;
          mCnt   <= spiAddrFlag ? 16 : 8;
          mState <= M_OPADDR;
        end
        M_OPADDR: begin
          if (mCnt == 1) begin
            sOaComp <= 1'b1;
            mState  <= M_GAP;
          end else mCnt <= mCnt - 1;
        end
        M_GAP: mState <= M_OPEN;
        M_OPEN: begin
          if (dTrig && (!isPP || pending > 0)) begin
            if (isPP) begin
              mosiLog.push_back({1'b0, spiWdata});
              mLatch = 1'b1;
            end
            sDReady <= 1'b1;
            mCnt    <= 8;
            mState  <= M_DATA;
          end else if (finTrig) begin
            mCnt   <= 3;
            mState <= M_FIN;
          end
        end
        M_DATA: begin
          if (mCnt == 1) begin
            sDComp <= 1'b1;
            if (!isPP) begin
              if (statusQ.size() > 0) sRead <= statusQ.pop_front();
              else sRead <= 8'h00;
            end
            mState <= M_GAP;
          end else mCnt <= mCnt - 1;
        end
        M_FIN: begin
          if (mCnt == 1) begin
            sBusy  <= 1'b0;
            mState <= M_IDLE;
          end else mCnt <= mCnt - 1;
        end
        default: mState <= M_IDLE;
      endcase
      pending <= pending + (byteReady ? 1 : 0) - (mLatch ? 1 : 0);
    end
  end

  // ---------------- byte stream source ----------------
  logic [7:0] txQ[$];
  int         stallAfter;
  int         stallCnt;
  int         readyCount;

  // Offers bytes in order; after byte number stallAfter is consumed the
  // stream goes quiet for 20 cycles.
  initial begin
    byteValid = 1'b0;
    byteData  = 8'h00;
    stallCnt  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        byteValid = 1'b0;
        stallCnt  = 0;
      end else if (stallCnt > 0) begin
        byteValid = 1'b0;
        stallCnt--;
      end else if (txQ.size() > 0) begin
        byteValid = 1'b1;
        byteData  = txQ[0];
        #1;
        if (byteReady) begin
          void'(txQ.pop_front());
          readyCount++;
          if (readyCount == stallAfter) stallCnt = 20;
        end
      end else begin
        byteValid = 1'b0;
      end
    end
  end

  // ---------------- per-cycle monitor ----------------
  int         cycle = 0;
  int         doneCount = 0;
  int         errorCount = 0;
  int         lastRelease = 0;
  int         lastEnd = 0;
  logic       prevOa = 1'b0;
  logic       prevSBusy = 1'b0;
  logic [7:0] prevOp = 8'h00;
  logic [7:0] prevAddr = 8'h00;
  logic       prevFlag = 1'b0;

  // Protocol rules checked on every out-of-reset cycle, mid-cycle.
  always @(negedge clk) begin
    #2;
    cycle++;
    if (rst) begin
      prevOa    = 1'b0;
      prevSBusy = 1'b0;
    end else begin
      checkOutput("oneTrigger", 32'($countones({oaTrig, dTrig, finTrig}) > 1), 32'd0);
      checkOutput("readyNeedsValid", 32'(byteReady & ~byteValid), 32'd0);
      checkOutput("doneErrorExclusive", 32'(done & error), 32'd0);
      checkOutput("dummyZero", 32'(spiDummy), 32'd0);
      checkOutput("busyDuringTraffic", 32'((oaTrig | dTrig | finTrig) & ~busy), 32'd0);
      checkOutput("addrFlagOnlyPpCmd", 32'(spiAddrFlag), 32'(oaTrig && spiOpcode == 8'h02));
      if (done | error) begin
        checkOutput("busyLowAtEnd", 32'(busy), 32'd0);
        lastEnd = cycle;
      end
      if (oaTrig && prevOa) begin
        checkOutput("opcodeStable", 32'(spiOpcode), 32'(prevOp));
        checkOutput("addrStable", 32'(spiAddr), 32'(prevAddr));
        checkOutput("flagStable", 32'(spiAddrFlag), 32'(prevFlag));
      end
      if (done) doneCount++;
      if (error) errorCount++;
      if (prevSBusy && !sBusy) lastRelease = cycle;
      prevOa    = oaTrig;
      prevOp    = spiOpcode;
      prevAddr  = spiAddr;
      prevFlag  = spiAddrFlag;
      prevSBusy = sBusy;
    end
  end

  // ---------------- stimulus and checking tasks ----------------
  logic [7:0] planBytes[$];
  logic [7:0] planStatus[$];
  logic [8:0] expLog[$];

  task automatic applyStimulus(input logic [7:0] addr, input int len);
    @(negedge clk);
    start     = 1'b1;
    startAddr = addr;
    length    = LEN_W'(len);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done/error beyond the given baseline, bounded by a budget.
  task automatic waitEnd(input int base, input int budget);
    int n = 0;
    while ((doneCount + errorCount) == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("endSeen", 32'(n < budget), 32'd1);
  endtask

  // Runs one transaction from planBytes/planStatus and compares the frame
  // log and pulse counts with what the transaction must produce.
  task automatic runTxn(input logic [7:0] addr, input int stallN, input bit startWhileBusy);
    int expPolls = 0;
    bit expErr   = 1'b1;
    int baseDone = doneCount;
    int baseErr  = errorCount;
    int n;
    expLog.delete();
    expLog.push_back(9'h106);
    expLog.push_back(9'h102);
    expLog.push_back({1'b0, addr});
    foreach (planBytes[i]) expLog.push_back({1'b0, planBytes[i]});
    for (int i = 0; i < POLL_LIMIT; i++) begin
      logic [7:0] s;
      expLog.push_back(9'h105);
      expPolls++;
      s = (i < planStatus.size()) ? planStatus[i] : 8'h00;
      if (!s[0]) begin
        expErr = 1'b0;
        break;
      end
    end

    mosiLog.delete();
    rdsrFrames = 0;
    statusQ    = planStatus;
    readyCount = 0;
    stallAfter = stallN;
    txQ        = planBytes;
    applyStimulus(addr, planBytes.size());
    if (startWhileBusy) begin
      repeat (30) @(negedge clk);
      checkOutput("busyBeforeSecondStart", 32'(busy), 32'd1);
      applyStimulus(8'h55, 3);
    end
    waitEnd(baseDone + baseErr, 3000);
    repeat (3) @(negedge clk);

    checkOutput("frameLogSize", 32'(mosiLog.size()), 32'(expLog.size()));
    n = (mosiLog.size() < expLog.size()) ? mosiLog.size() : expLog.size();
    for (int i = 0; i < n; i++) checkOutput($sformatf("frameLog[%0d]", i), 32'(mosiLog[i]), 32'(expLog[i]));
    checkOutput("byteReadyCount", 32'(readyCount), 32'(planBytes.size()));
    checkOutput("rdsrFrames", 32'(rdsrFrames), 32'(expPolls));
    checkOutput("donePulses", 32'(doneCount - baseDone), 32'(!expErr));
    checkOutput("errorPulses", 32'(errorCount - baseErr), 32'(expErr));
    checkOutput("endAfterRelease", 32'(lastEnd - lastRelease), 32'd1);
    checkOutput("busyIdle", 32'(busy), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    startAddr = 8'h00;
    length    = '0;
    repeat (3) @(negedge clk);
    #3;
    checkOutput("rst_opcode", 32'(spiOpcode), 32'h06);
    checkOutput("rst_triggers", 32'({oaTrig, dTrig, finTrig}), 32'd0);
    checkOutput("rst_status", 32'({busy, done, error, byteReady, spiAddrFlag}), 32'd0);
    checkOutput("rst_addr_wdata", 32'({spiAddr, spiWdata, spiDummy}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte, status clear on the first poll.
    $display("[TB] single byte");
    planBytes.delete(); planBytes.push_back(8'h12);
    planStatus.delete(); planStatus.push_back(8'h00);
    runTxn(8'hAB, 0, 1'b0);
    checkOutput("lit_single_size", 32'(mosiLog.size()), 32'd5);
    if (mosiLog.size() == 5) begin
      checkOutput("lit_single_0", 32'(mosiLog[0]), 32'h106);
      checkOutput("lit_single_1", 32'(mosiLog[1]), 32'h102);
      checkOutput("lit_single_2", 32'(mosiLog[2]), 32'h0AB);
      checkOutput("lit_single_3", 32'(mosiLog[3]), 32'h012);
      checkOutput("lit_single_4", 32'(mosiLog[4]), 32'h105);
    end

    // Burst of four with the stream stalling before the third byte.
    $display("[TB] burst of 4 with stall");
    planBytes.delete();
    planBytes.push_back(8'h11); planBytes.push_back(8'h22);
    planBytes.push_back(8'h33); planBytes.push_back(8'h44);
    planStatus.delete(); planStatus.push_back(8'h00);
    runTxn(8'h40, 2, 1'b0);

    // WIP stays set for two polls.
    $display("[TB] WIP polling");
    planBytes.delete(); planBytes.push_back(8'hC3);
    planStatus.delete();
    planStatus.push_back(8'h01); planStatus.push_back(8'h01); planStatus.push_back(8'h00);
    runTxn(8'h07, 0, 1'b0);
    checkOutput("lit_wip_polls", 32'(rdsrFrames), 32'd3);

    // WIP never clears: poll budget exhausted.
    $display("[TB] poll timeout");
    base = errorCount;
    planBytes.delete(); planBytes.push_back(8'h9E);
    planStatus.delete();
    for (int i = 0; i < 6; i++) planStatus.push_back(8'h01);
    runTxn(8'hF0, 0, 1'b0);
    checkOutput("lit_timeout_polls", 32'(rdsrFrames), 32'd4);
    checkOutput("lit_timeout_error", 32'(errorCount - base), 32'd1);

    // Zero length: done next cycle, no bus traffic.
    $display("[TB] zero length");
    base = doneCount;
    mosiLog.delete();
    applyStimulus(8'h33, 0);
    #3;
    checkOutput("len0_done", 32'(done), 32'd1);
    checkOutput("len0_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("len0_donePulses", 32'(doneCount - base), 32'd1);
    checkOutput("len0_noTraffic", 32'(mosiLog.size()), 32'd0);

    // Second start while a transaction is running must be ignored.
    $display("[TB] start while busy");
    planBytes.delete(); planBytes.push_back(8'h77); planBytes.push_back(8'h88);
    planStatus.delete(); planStatus.push_back(8'h00);
    runTxn(8'h5C, 0, 1'b1);
    n = 0;
    foreach (mosiLog[i]) if (mosiLog[i] == 9'h106) n++;
    checkOutput("busyStart_wrenFrames", 32'(n), 32'd1);

    // Reset in the middle of the data phase.
    $display("[TB] reset during data phase");
    mosiLog.delete();
    statusQ.delete(); statusQ.push_back(8'h00);
    readyCount = 0;
    stallAfter = 2;
    txQ.delete();
    txQ.push_back(8'hA1); txQ.push_back(8'hA2); txQ.push_back(8'hA3); txQ.push_back(8'hA4);
    applyStimulus(8'h20, 4);
    n = 0;
    while (readyCount < 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rstMid_twoBytesTaken", 32'(readyCount), 32'd2);
    repeat (3) @(negedge clk);
    #3;
    checkOutput("rstMid_dataTrigHeld", 32'(dTrig), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstMid_triggers", 32'({oaTrig, dTrig, finTrig}), 32'd0);
    checkOutput("rstMid_busy", 32'(busy), 32'd0);
    txQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] single byte after reset");
    planBytes.delete(); planBytes.push_back(8'h3C);
    planStatus.delete(); planStatus.push_back(8'h00);
    runTxn(8'h10, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/spi_page_write_ctrl.md
Name: spi_page_write_ctrl

Overview:
Sequencer that drives spi_memory_master to perform a complete page-program transaction on an external SPI flash/SRAM. The sequence is WREN, then PAGE PROGRAM with address and N data bytes, then RDSR polling until the write-in-progress bit clears. It sits between the frame-buffer/readout logic, which supplies bytes through a valid/ready stream, and the SPI master. It owns all master trigger lines.

Parameters:
ADDR_BYTES, 1, address width in bytes; must match the master's address parameter.
LEN_W, 9, width of the length field (max burst 2^LEN_W-1 bytes).
POLL_LIMIT, 1024, maximum RDSR attempts before error.
OP_WREN, 8'h06, write-enable opcode.
OP_PP, 8'h02, page-program opcode.
OP_RDSR, 8'h05, read-status opcode.

Ports:
main_clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
start_addr  in  8*ADDR_BYTES  target address, latched on start
length  in  LEN_W  byte count, latched on start; 0 is legal (no PP, done immediately)
byte_data  in  8  stream byte to write
byte_valid  in  1  stream byte present
byte_ready  out  1  one-cycle pulse: byte_data consumed
busy  out  1  high from accepted start until done/error
done  out  1  one-cycle pulse: transaction finished, WIP=0
error  out  1  one-cycle pulse: poll limit exceeded
spi_opcode  out  8  to master opcode
spi_addr  out  8*ADDR_BYTES  to master addr
spi_addr_flag  out  1  1 only during PP command phase
spi_dummy_cycles  out  4  constant 0
spi_write_data  out  8  to master write_data
spi_read_data  in  8  from master read_data
spi_opcode_addr_trigger  out  1  level request for opcode/address phase
spi_opcode_addr_completed  in  1  master: opcode/addr phase done
spi_data_trigger  out  1  level request for a data byte
spi_data_ready  in  1  master: current byte latched, next may be presented
spi_data_completed  in  1  master: byte shift finished
spi_finalize_trigger  out  1  level request to release CS
spi_busy  in  1  master active

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0; spi_opcode = OP_WREN.
- Reset mid-transaction drops all triggers immediately. CS release is left to the master's own reset.
- Trigger rule: each trigger is held high until its acknowledge is seen, then dropped the next cycle.
  - opcode_addr_trigger is acknowledged by spi_opcode_addr_completed.
  - data_trigger is acknowledged by spi_data_completed of the last byte.
  - finalize_trigger is acknowledged by spi_busy=0.
- Never assert more than one trigger in the same cycle.
- spi_opcode, spi_addr and spi_addr_flag are stable while their trigger is high.
- States:
  - IDLE: on start (length>0): latch addr/length, busy=1, go WREN_CMD. On start with length=0: pulse done next cycle, stay IDLE.
  - WREN_CMD: opcode=OP_WREN, addr_flag=0, trigger until completed, go WREN_FIN.
  - WREN_FIN: finalize until spi_busy=0, go PP_CMD.
  - PP_CMD: opcode=OP_PP, addr=latched, addr_flag=1, trigger until completed, go PP_WAIT.
  - PP_WAIT: wait for byte_valid. On valid: load spi_write_data, pulse byte_ready, assert data_trigger, go PP_DATA.
  - PP_DATA: on spi_data_ready, decrement remaining.
    - If remaining>0: require byte_valid. If invalid, hold the current byte and keep trigger high, since the master stalls by not ending the phase. When valid, load the next byte and pulse byte_ready.
    - On spi_data_completed with remaining=0: drop data_trigger, go PP_FIN.
  - PP_FIN: finalize, go POLL_CMD.
  - POLL_CMD: opcode=OP_RDSR, addr_flag=0, trigger, go POLL_DATA.
  - POLL_DATA: data_trigger until spi_data_completed, capture spi_read_data, go POLL_FIN.
  - POLL_FIN: finalize.
    - If captured bit0=0: pulse done, go IDLE.
    - Else if poll count = POLL_LIMIT-1: pulse error, go IDLE.
    - Else increment poll count, go POLL_CMD.
- byte_ready pulses exactly `length` times per transaction, never when byte_valid=0.
- start while busy is ignored.
- done and error are mutually exclusive. busy falls in the same cycle as the done/error pulse.
- Polling attempts: count the first attempt as 1.

Test Plan:
- Single byte: start_addr=8'hAB, length=1, byte 8'h12 valid, master model returns status 8'h00 → MOSI shows 06 / 02 AB 12 / 05; one byte_ready; done one cycle after final CS release.
- Burst of 4: bytes 11,22,33,44, valid deasserted 20 cycles before byte 3 → four byte_ready pulses in order; MOSI data sequence 11 22 33 44 with no duplicate or skipped byte.
- WIP polling: status returns 01,01,00 → three RDSR frames, then done; error never asserted.
- Timeout: POLL_LIMIT=4, status always 01 → exactly 4 RDSR frames, error pulse, busy=0, done never asserted.
- Reset during PP_DATA after 2 of 4 bytes → all triggers 0 in the same cycle, busy=0. A subsequent start of length 1 completes normally.
- Edge cases:
  - start with length=0 → done pulse, no SPI traffic.
  - start while busy → ignored, transaction count unchanged.
